// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Watches a multiplexed, active-low seven-segment bus and recovers the hex
//   nibble shown on each digit position. Serves as a display monitor and as a
//   loopback checker for display drivers.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   AN           observed anodes, active-low, bit i = digit i
//   hex          observed segments, active-low, bit0=a .. bit6=g
//   clr          synchronous clear of the sticky error flags
//   value        decoded nibbles, digit i at [4i+3:4i]
//   blank        digit i last accepted with all segments off
//   digit_seen   digits accepted since the last completed frame
//   frame_valid  one-cycle pulse when every digit has been accepted
//   seg_error    sticky, an undecodable pattern was accepted
//   scan_error   sticky, several anodes were low and stable
//   active       scan alive (an acceptance within the timeout window)
//
// state       | meaning
// ST_IDLE     | no single valid anode on the synchronized bus
// ST_TRACK    | one anode low, waiting for the pattern to hold steady
// ST_HOLD     | current pattern accepted, waiting for the bus to change
module seg_scan_decoder #(
    parameter int NUM_DIGITS     = 8,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_DIGITS-1:0]     AN,
    input  logic [6:0]                hex,
    input  logic                      clr,
    output logic [4*NUM_DIGITS-1:0]   value,
    output logic [NUM_DIGITS-1:0]     blank,
    output logic [NUM_DIGITS-1:0]     digit_seen,
    output logic                      frame_valid,
    output logic                      seg_error,
    output logic                      scan_error,
    output logic                      active
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [NUM_DIGITS-1:0] an_m, an_s, an_p;
    logic [6:0]            hex_m, hex_s, hex_p;
    logic [SW-1:0]         stab_cnt, stab_nxt;
    logic [TW-1:0]         tmo_cnt;
    logic [1:0]            state, state_nxt;

    logic [NUM_DIGITS-1:0] an_low, seen_nxt;
    logic                  one_hot, multi_hot, changed, reached;
    logic                  accept, frame_done, timeout, seg_set, scan_set;
    logic                  dec_ok, is_blank;
    logic [3:0]            dec_nib;

    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b100_0000: seg_decode = 5'h10;
            7'b111_1001: seg_decode = 5'h11;
            7'b010_0100: seg_decode = 5'h12;
            7'b011_0000: seg_decode = 5'h13;
            7'b001_1001: seg_decode = 5'h14;
            7'b001_0010: seg_decode = 5'h15;
            7'b000_0010: seg_decode = 5'h16;
            7'b111_1000: seg_decode = 5'h17;
            7'b000_0000: seg_decode = 5'h18;
            7'b001_0000: seg_decode = 5'h19;
            7'b000_1000: seg_decode = 5'h1A;
            7'b000_0011: seg_decode = 5'h1B;
            7'b100_0110: seg_decode = 5'h1C;
            7'b010_0001: seg_decode = 5'h1D;
            7'b000_0110: seg_decode = 5'h1E;
            7'b000_1110: seg_decode = 5'h1F;
            default:     seg_decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        an_low    = ~an_s;
        one_hot   = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);
        multi_hot = (an_low != '0) && !one_hot;
        changed   = (an_s != an_p) || (hex_s != hex_p);

        if (changed)
            stab_nxt = SW'(1);
        else if (stab_cnt == SW'(STABLE_CYCLES))
            stab_nxt = stab_cnt;
        else
            stab_nxt = stab_cnt + 1'b1;

        // Rising into the stable count, so a held multi-hot bus flags once.
        reached = (stab_nxt == SW'(STABLE_CYCLES)) && (stab_cnt != SW'(STABLE_CYCLES));

        {dec_ok, dec_nib} = seg_decode(hex_s);
        is_blank   = (hex_s == 7'h7F);
        accept     = (state == ST_TRACK) && one_hot && (stab_nxt == SW'(STABLE_CYCLES));
        seen_nxt   = digit_seen | an_low;
        frame_done = accept && (&seen_nxt);
        seg_set    = accept && !dec_ok && !is_blank;
        scan_set   = multi_hot && reached;
        timeout    = active && !accept && (tmo_cnt == TW'(1));

        state_nxt = state;
        case (state)
            ST_IDLE:  if (one_hot) state_nxt = ST_TRACK;
            ST_TRACK: begin
                if (!one_hot)
                    state_nxt = ST_IDLE;
                else if (stab_nxt == SW'(STABLE_CYCLES))
                    state_nxt = ST_HOLD;
            end
            ST_HOLD:  if (changed) state_nxt = one_hot ? ST_TRACK : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_m        <= '1;
            an_s        <= '1;
            an_p        <= '1;
            hex_m       <= '1;
            hex_s       <= '1;
            hex_p       <= '1;
            stab_cnt    <= '0;
            tmo_cnt     <= '0;
            state       <= ST_IDLE;
            value       <= '0;
            blank       <= '1;
            digit_seen  <= '0;
            frame_valid <= 1'b0;
            seg_error   <= 1'b0;
            scan_error  <= 1'b0;
            active      <= 1'b0;
        end else begin
            an_m     <= AN;
            an_s     <= an_m;
            an_p     <= an_s;
            hex_m    <= hex;
            hex_s    <= hex_m;
            hex_p    <= hex_s;
            stab_cnt <= stab_nxt;
            state    <= state_nxt;

            frame_valid <= frame_done;
            seg_error   <= (seg_error & ~clr) | seg_set;
            scan_error  <= (scan_error & ~clr) | scan_set;

            if (accept) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (an_low[i]) begin
                        value[4*i +: 4] <= dec_ok ? dec_nib : 4'h0;
                        blank[i]        <= is_blank;
                    end
                end
                digit_seen <= frame_done ? '0 : seen_nxt;
                tmo_cnt    <= TW'(TIMEOUT_CYCLES);
                active     <= 1'b1;
            end else if (timeout) begin
                digit_seen <= '0;
                active     <= 1'b0;
            end else if (active) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end
        end
    end

endmodule
